// File: rtl/fetch_queue_pkg.sv
// Constants shared by the IFU, fetch_queue and decode.
package fetch_queue_pkg;

  localparam int unsigned FQ_W          = 32;
  localparam logic [31:0] TEXT_START_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle: IFU is the master, the fetch queue is the slave.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned W = FQ_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_PC;
  logic [W-1:0] in_inStr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_PC;
  logic [W-1:0] out_inStr;

  modport master (
    output in_valid, in_PC, in_inStr, out_ready,
    input  in_ready, out_valid, out_PC, out_inStr
  );

  modport slave (
    input  in_valid, in_PC, in_inStr, out_ready,
    output in_ready, out_valid, out_PC, out_inStr
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// DEPTH x DW register array: synchronous write, asynchronous read.
module fq_storage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {PC, instruction} pairs with
// first-word fall-through output and a flush that empties the queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = FQ_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  fetch_queue_if.slave                 q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           push;
  logic           pop;
  logic           wr_en;
  logic [2*W-1:0] rdata;

  // Handshake flags depend only on registered occupancy, never on out_ready.
  assign q.in_ready  = (count != CW'(DEPTH));
  assign q.out_valid = (count != '0);

  assign push  = q.in_valid & q.in_ready;
  assign pop   = q.out_valid & q.out_ready;
  assign wr_en = push & reset & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .DW    (2*W),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wp),
    .wdata ({q.in_PC, q.in_inStr}),
    .raddr (rp),
    .rdata (rdata)
  );

  assign q.out_PC    = rdata[2*W-1:W];
  assign q.out_inStr = rdata[W-1:0];

endmodule
